// File: rtl/bsg_sha256_padder.sv
// SHA-256 message padder.
// Collects 32-bit big-endian message words into a 512-bit block and adds the
// FIPS 180-4 padding: a 0x80 marker byte, zero fill, and the 64-bit message
// bit length. Blocks are offered downstream with a valid/yumi handshake.
// last_o marks the final block of a message.
//
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   v_i, data_i         input word and its valid (first byte in [31:24])
//   last_i              data_i is the final word of the message
//   last_bytes_i        valid bytes in the final word (0 means 4)
//   ready_o             a word can be accepted this cycle
//   v_o, data_o         complete block (word 0 in [511:480])
//   last_o              block is the final block of the message
//   yumi_i              downstream consumes the block
module bsg_sha256_padder #(
    parameter int unsigned len_width_p = 64
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         v_i,
    input  logic [31:0]  data_i,
    input  logic         last_i,
    input  logic [1:0]   last_bytes_i,
    output logic         ready_o,
    output logic         v_o,
    output logic [511:0] data_o,
    output logic         last_o,
    input  logic         yumi_i
);

    localparam int unsigned word_width_lp = 32;
    localparam int unsigned words_lp      = 16;
    localparam int unsigned len_field_lp  = 64;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        SEND      = 2'd1,
        SEND_PRE  = 2'd2,
        SEND_LAST = 2'd3
    } state_e;

    state_e                                       state_r, state_n;
    // Element 15 holds message word 0 so the packed vector maps directly to data_o.
    logic [words_lp-1:0][word_width_lp-1:0]       blk_r, blk_n;
    logic [3:0]                                   idx_r, idx_n;
    logic [len_width_p-1:0]                       len_r, len_n;
    // Final data block was full with no room for the marker; the length block carries it.
    logic                                         p16_r, p16_n;

    logic [2:0]                 n_bytes;
    logic                       full_last;
    logic [word_width_lp-1:0]   last_word;
    logic [4:0]                 idx5;
    logic [4:0]                 mark_pos;
    logic [len_width_p-1:0]     len_final;
    logic [len_field_lp-1:0]    len_final64;
    logic [len_field_lp-1:0]    len_cur64;

    // Handshake outputs decoded directly from the state register.
    assign ready_o = (state_r == FILL) & ~reset_i;
    assign v_o     = (state_r != FILL);
    assign last_o  = (state_r == SEND_LAST);
    assign data_o  = blk_r;

    // Final-word decode: byte count, marker insertion, and resulting length.
    always_comb begin
        n_bytes   = (last_bytes_i == 2'b00) ? 3'd4 : {1'b0, last_bytes_i};
        full_last = (last_bytes_i == 2'b00);
        unique case (last_bytes_i)
            2'b01:   last_word = {data_i[31:24], 8'h80, 16'h0000};
            2'b10:   last_word = {data_i[31:16], 8'h80, 8'h00};
            2'b11:   last_word = {data_i[31:8],  8'h80};
            default: last_word = data_i;
        endcase
        idx5        = {1'b0, idx_r};
        mark_pos    = full_last ? (idx5 + 5'd1) : idx5;
        len_final   = len_r + len_width_p'({n_bytes, 3'b000});
        len_final64 = len_field_lp'(len_final);
        len_cur64   = len_field_lp'(len_r);
    end

    // Next-state and datapath update.
    always_comb begin
        state_n = state_r;
        blk_n   = blk_r;
        idx_n   = idx_r;
        len_n   = len_r;
        p16_n   = p16_r;

        unique case (state_r)
            FILL: begin
                if (v_i && ready_o) begin
                    if (!last_i) begin
                        blk_n[4'(15 - int'(idx_r))] = data_i;
                        len_n = len_r + len_width_p'(32);
                        idx_n = idx_r + 4'd1;
                        if (idx_r == 4'd15) begin
                            state_n = SEND;
                        end
                    end else begin
                        len_n = len_final;
                        for (int w = 0; w < 16; w++) begin
                            if (5'(w) == idx5) begin
                                blk_n[4'(15 - w)] = last_word;
                            end else if (5'(w) > idx5) begin
                                blk_n[4'(15 - w)] =
                                    (full_last && (5'(w) == idx5 + 5'd1)) ? 32'h8000_0000 : 32'h0;
                            end
                        end
                        // Length fits in this block only if the marker ends by word 13.
                        if (mark_pos <= 5'd13) begin
                            blk_n[1] = len_final64[63:32];
                            blk_n[0] = len_final64[31:0];
                            state_n  = SEND_LAST;
                        end else begin
                            state_n  = SEND_PRE;
                        end
                        p16_n = (mark_pos == 5'd16);
                    end
                end
            end

            SEND: begin
                if (yumi_i) begin
                    state_n = FILL;
                end
            end

            SEND_PRE: begin
                // Build the extra length-only block.
                if (yumi_i) begin
                    blk_n     = '0;
                    blk_n[15] = p16_r ? 32'h8000_0000 : 32'h0;
                    blk_n[1]  = len_cur64[63:32];
                    blk_n[0]  = len_cur64[31:0];
                    state_n   = SEND_LAST;
                end
            end

            SEND_LAST: begin
                if (yumi_i) begin
                    len_n   = '0;
                    idx_n   = '0;
                    p16_n   = 1'b0;
                    state_n = FILL;
                end
            end

            default: state_n = FILL;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= FILL;
            blk_r   <= '0;
            idx_r   <= '0;
            len_r   <= '0;
            p16_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            blk_r   <= blk_n;
            idx_r   <= idx_n;
            len_r   <= len_n;
            p16_r   <= p16_n;
        end
    end

endmodule

// File: tb/tb_bsg_sha256_padder.sv
// Self-checking bench for bsg_sha256_padder: directed plan cases plus random
// messages compared against a byte-level FIPS 180-4 padding model.
module tb_bsg_sha256_padder;

    logic         clk_i;
    logic         reset_i;
    logic         v_i;
    logic [31:0]  data_i;
    logic         last_i;
    logic [1:0]   last_bytes_i;
    logic         ready_o;
    logic         v_o;
    logic [511:0] data_o;
    logic         last_o;
    logic         yumi_i;

    bsg_sha256_padder #(.len_width_p(64)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .data_i       (data_i),
        .last_i       (last_i),
        .last_bytes_i (last_bytes_i),
        .ready_o      (ready_o),
        .v_o          (v_o),
        .data_o       (data_o),
        .last_o       (last_o),
        .yumi_i       (yumi_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    byte unsigned msg_q[$];
    logic [511:0] exp_blk[$];
    logic         exp_last[$];
    logic [511:0] last_seen_blk;
    int           hold_override = -1;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected progress", tag);
    endtask

    // Reference: standard byte-oriented padding, split into 64-byte blocks.
    task automatic model();
        byte unsigned p[$];
        longint unsigned bitlen;
        int nblk;
        logic [511:0] b;
        p = msg_q;
        bitlen = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bitlen >> (8 * i)));
        nblk = p.size() / 64;
        for (int k = 0; k < nblk; k++) begin
            b = '0;
            for (int j = 0; j < 64; j++) b[511 - 8 * j -: 8] = p[64 * k + j];
            exp_blk.push_back(b);
            exp_last.push_back(k == nblk - 1);
        end
    endtask

    // Precondition: v_o sampled high. Checks, optionally stalls, then consumes.
    task automatic consume_block();
        logic [511:0] d;
        logic         l;
        int           hold;
        if (exp_blk.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_block: observed %0h expected none", data_o);
        end else begin
            chk("block_data", data_o, exp_blk.pop_front());
            chk("block_last", 512'(last_o), 512'(exp_last.pop_front()));
        end
        last_seen_blk = data_o;
        d = data_o;
        l = last_o;
        hold = (hold_override >= 0) ? hold_override : int'($urandom_range(0, 2));
        for (int i = 0; i < hold; i++) begin
            v_i          = 1'b1;
            data_i       = $urandom;
            last_i       = 1'($urandom);
            last_bytes_i = 2'($urandom);
            step();
            chk("hold_v",     512'(v_o),     512'(1'b1));
            chk("hold_ready", 512'(ready_o), 512'(1'b0));
            chk("hold_data",  data_o,        d);
            chk("hold_last",  512'(last_o),  512'(l));
        end
        v_i    = 1'b0;
        last_i = 1'b0;
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
    endtask

    // Drives the message in msg_q, consuming blocks as they appear.
    task automatic send_msg();
        int L, nw, guard;
        logic [31:0] w;
        logic lastw;
        L  = msg_q.size();
        nw = (L + 3) / 4;
        model();
        for (int k = 0; k < nw; k++) begin
            w = $urandom;
            for (int j = 0; j < 4; j++)
                if (4 * k + j < L) w[31 - 8 * j -: 8] = msg_q[4 * k + j];
            lastw = (k == nw - 1);
            guard = 0;
            while (1) begin
                if (v_o) consume_block();
                else if (ready_o) break;
                else begin
                    step();
                    guard++;
                    if (guard > 100) begin
                        fail_now("wait_ready");
                        return;
                    end
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                v_i = 1'b0;
                step();
            end
            v_i          = 1'b1;
            data_i       = w;
            last_i       = lastw;
            last_bytes_i = lastw ? 2'(L % 4) : 2'($urandom);
            step();
            v_i    = 1'b0;
            last_i = 1'b0;
        end
        chk("last_latency", 512'(v_o), 512'(1'b1));
        while (exp_blk.size() > 0) begin
            guard = 0;
            while (!v_o) begin
                step();
                guard++;
                if (guard > 50) begin
                    fail_now("wait_block");
                    exp_blk.delete();
                    exp_last.delete();
                    return;
                end
            end
            consume_block();
        end
        chk("ready_after", 512'(ready_o), 512'(1'b1));
        chk("idle_after",  512'(v_o),     512'(1'b0));
    endtask

    task automatic set_abc();
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
    endtask

    initial begin
        logic [511:0] abc_exp;
        abc_exp = {32'h61626380, 448'h0, 32'h00000018};

        reset_i      = 1'b1;
        v_i          = 1'b0;
        data_i       = '0;
        last_i       = 1'b0;
        last_bytes_i = '0;
        yumi_i       = 1'b0;
        step();
        step();
        chk("reset_v",     512'(v_o),     512'(1'b0));
        chk("reset_last",  512'(last_o),  512'(1'b0));
        chk("reset_data",  data_o,        512'h0);
        chk("reset_ready", 512'(ready_o), 512'(1'b0));
        reset_i = 1'b0;
        step();
        chk("ready_post_reset", 512'(ready_o), 512'(1'b1));

        // "abc" in one partial word.
        set_abc();
        send_msg();
        chk("abc_const", last_seen_blk, abc_exp);

        // Single full final word.
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62);
        msg_q.push_back(8'h63); msg_q.push_back(8'h64);
        send_msg();
        chk("full_word_const", last_seen_blk, {32'h61626364, 32'h80000000, 416'h0, 32'h00000020});

        // 14 full words: marker in word 14, length spills to a second block.
        msg_q.delete();
        for (int i = 0; i < 56; i++) msg_q.push_back(8'($urandom));
        send_msg();
        chk("spill_len_const", last_seen_blk, {480'h0, 32'h000001C0});

        // 16 full words then one byte; first block stalled for 5 cycles.
        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'($urandom));
        msg_q.push_back(8'hAB);
        hold_override = 5;
        send_msg();
        hold_override = -1;
        chk("one_byte_const", last_seen_blk, {32'hAB800000, 448'h0, 32'h00000208});

        // Reset mid-message after 7 words, then "abc" must come out clean.
        for (int i = 0; i < 7; i++) begin
            v_i    = 1'b1;
            data_i = $urandom;
            last_i = 1'b0;
            step();
        end
        v_i     = 1'b0;
        reset_i = 1'b1;
        step();
        chk("midreset_ready", 512'(ready_o), 512'(1'b0));
        chk("midreset_v",     512'(v_o),     512'(1'b0));
        chk("midreset_data",  data_o,        512'h0);
        reset_i = 1'b0;
        step();
        set_abc();
        send_msg();
        chk("abc_after_reset", last_seen_blk, abc_exp);

        // Sweep lengths around the marker/length boundary (words 13..16).
        for (int L = 50; L <= 70; L++) begin
            msg_q.delete();
            for (int i = 0; i < L; i++) msg_q.push_back(8'($urandom));
            send_msg();
        end

        // Random messages.
        for (int m = 0; m < 40; m++) begin
            int L;
            L = int'($urandom_range(1, 200));
            msg_q.delete();
            for (int i = 0; i < L; i++) msg_q.push_back(8'($urandom));
            send_msg();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
